// File: rtl/video_stream_packer.sv
// Packs 24-bit video pixels into AXI4-width words with burst-request beat accounting.
// Define VIDEO_PACK_LINE_FLUSH_EN to flush a left-justified partial word at every line end.
module video_stream_packer #(
    parameter int         AXI4_DATA_WIDTH = 128,
    parameter logic [7:0] PAD_BYTE        = 8'hff,
    parameter int         BURST_BEATS     = 16
) (
    input  logic                       video_clk,
    input  logic                       video_rst,
    input  logic                       video_vs_out,
    input  logic                       video_hs_out,
    input  logic                       video_de_out,
    input  logic [23:0]                video_data_out,
    output logic [AXI4_DATA_WIDTH-1:0] fifo_data_out,
    output logic                       fifo_enable,
    input  logic                       fifo_full,
    output logic                       AXI_FULL_BURST_VALID,
    input  logic                       AXI_FULL_BURST_READY,
    output logic                       overflow,
    output logic [15:0]                line_beats
);

    localparam int              SLOTS     = AXI4_DATA_WIDTH / 32;
    localparam int              CNT_W     = $clog2(SLOTS);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);
    localparam logic [15:0]     BURST_LEN = 16'(BURST_BEATS);

    typedef enum logic {IDLE, REQ} burst_state_t;

    burst_state_t               state, state_next;
    logic                       vs_d1, de_d1;
    logic [CNT_W-1:0]           slot_cnt;
    // Only SLOTS-1 slots are ever buffered; the last slot goes straight to the output word.
    logic [AXI4_DATA_WIDTH-33:0] pix_buf;
    logic [15:0]                pend_beats, pend_next, line_cnt;
    logic [16:0]                pend_sum;
    logic [31:0]                new_slot;
    logic [AXI4_DATA_WIDTH-1:0] shift_word, emit_word;
    logic                       frame_start, line_end, line_start;
    logic                       word_done, flush_now, emit, accept;
    logic                       unused_hs;
`ifdef VIDEO_PACK_LINE_FLUSH_EN
    logic [AXI4_DATA_WIDTH-1:0] flush_word;
`endif

    assign unused_hs   = video_hs_out;
    assign frame_start = video_vs_out && !vs_d1;
    assign line_end    = !video_de_out && de_d1;
    assign line_start  = video_de_out && !de_d1;

    // NOTE: every signal written in an always_comb gets a default at the top, so no path can infer a latch.
    always_comb begin
        new_slot   = {PAD_BYTE, video_data_out};
        shift_word = {pix_buf, new_slot};
        word_done  = video_de_out && (slot_cnt == LAST_SLOT);
`ifdef VIDEO_PACK_LINE_FLUSH_EN
        flush_now  = line_end && (slot_cnt != '0);
        flush_word = {32'h0, pix_buf} << (32 * (SLOTS - int'(slot_cnt)));
        for (int i = 0; i < SLOTS; i++)
            if (i < SLOTS - int'(slot_cnt))
                flush_word[i*32 +: 32] = {PAD_BYTE, 24'h0};
        emit_word  = flush_now ? flush_word : shift_word;
`else
        flush_now  = 1'b0;
        emit_word  = shift_word;
`endif
        emit       = word_done || flush_now;
    end

    always_comb begin
        accept     = (state == REQ) && AXI_FULL_BURST_READY;
        state_next = state;
        case (state)
            IDLE:    if (pend_beats >= BURST_LEN) state_next = REQ;
            REQ:     if (accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (frame_start)
            state_next = IDLE;
        AXI_FULL_BURST_VALID = (state == REQ);

        pend_sum = {1'b0, pend_beats} + {16'h0, fifo_enable};
        if (accept)
            pend_sum = pend_sum - {1'b0, BURST_LEN};
        pend_next = pend_sum[16] ? 16'hffff : pend_sum[15:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge video_clk) begin
        if (video_rst) begin
            state         <= IDLE;
            vs_d1         <= 1'b0;
            de_d1         <= 1'b0;
            slot_cnt      <= '0;
            pix_buf       <= '0;
            pend_beats    <= '0;
            line_cnt      <= '0;
            line_beats    <= '0;
            fifo_data_out <= '0;
            fifo_enable   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            vs_d1       <= video_vs_out;
            de_d1       <= video_de_out;
            state       <= state_next;
            fifo_enable <= 1'b0;
            if (frame_start) begin
                slot_cnt   <= '0;
                pix_buf    <= '0;
                pend_beats <= '0;
                line_cnt   <= '0;
                overflow   <= 1'b0;
            end else begin
                pend_beats <= pend_next;
                if (video_de_out) begin
                    pix_buf  <= shift_word[AXI4_DATA_WIDTH-33:0];
                    slot_cnt <= word_done ? '0 : slot_cnt + 1'b1;
                end else if (flush_now) begin
                    slot_cnt <= '0;
                end
                if (emit) begin
                    fifo_data_out <= emit_word;
                    fifo_enable   <= 1'b1;
                end
                // The word emitted alongside a line edge belongs to that line's count.
                if (line_start)
                    line_cnt <= {15'h0, emit};
                else if (emit)
                    line_cnt <= line_cnt + 16'd1;
                if (line_end)
                    line_beats <= line_cnt + {15'h0, emit};
                if (fifo_enable && fifo_full)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_stream_packer.sv
// Scoreboard bench for video_stream_packer (W=128, BURST_BEATS=4); follows VIDEO_PACK_LINE_FLUSH_EN.
module tb_video_stream_packer;

    localparam int W = 128;
    localparam int N = W / 32;
    localparam int B = 4;

    logic         video_clk = 1'b0;
    logic         video_rst, video_vs_out, video_hs_out, video_de_out;
    logic [23:0]  video_data_out;
    logic [W-1:0] fifo_data_out;
    logic         fifo_enable, fifo_full;
    logic         AXI_FULL_BURST_VALID, AXI_FULL_BURST_READY;
    logic         overflow;
    logic [15:0]  line_beats;

    video_stream_packer #(
        .AXI4_DATA_WIDTH(W),
        .PAD_BYTE       (8'hff),
        .BURST_BEATS    (B)
    ) dut (
        .video_clk           (video_clk),
        .video_rst           (video_rst),
        .video_vs_out        (video_vs_out),
        .video_hs_out        (video_hs_out),
        .video_de_out        (video_de_out),
        .video_data_out      (video_data_out),
        .fifo_data_out       (fifo_data_out),
        .fifo_enable         (fifo_enable),
        .fifo_full           (fifo_full),
        .AXI_FULL_BURST_VALID(AXI_FULL_BURST_VALID),
        .AXI_FULL_BURST_READY(AXI_FULL_BURST_READY),
        .overflow            (overflow),
        .line_beats          (line_beats)
    );

    always #5 video_clk = ~video_clk;

    int           n_cmp = 0, n_bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_words[$];
    logic [23:0]  pix_q[$];
    int           line_words = 0;
    int           enable_count = 0, hs_count = 0, b2b_count = 0, valid_rises = 0;
    int           cyc = 0, cross_cyc = 0, lat_target = 0;
    logic         lat_done = 1'b0, prev_hs = 1'b0, prev_valid = 1'b0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    task automatic push_word(input logic [W-1:0] w);
        exp_q.push_back(w);
        line_words++;
    endtask

    task automatic model_pixel(input logic [23:0] px);
        logic [W-1:0] w;
        pix_q.push_back(px);
        if (pix_q.size() == N) begin
            w = '0;
            foreach (pix_q[k]) w = {w[W-33:0], 8'hff, pix_q[k]};
            push_word(w);
            pix_q.delete();
        end
    endtask

    task automatic model_flush();
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < N; k++)
            w = {w[W-33:0], 8'hff, (k < pix_q.size()) ? pix_q[k] : 24'h0};
        push_word(w);
        pix_q.delete();
    endtask

    task automatic send_line(input int first, input int count);
        line_words = 0;
        for (int i = 0; i < count; i++) begin
            video_de_out   = 1'b1;
            video_data_out = 24'(first + i);
            model_pixel(24'(first + i));
            tick();
        end
        video_de_out = 1'b0;
`ifdef VIDEO_PACK_LINE_FLUSH_EN
        if (pix_q.size() != 0) model_flush();
`endif
        tick();
        tick();
        tick();
        check("line_beats", line_beats, line_words);
    endtask

    task automatic frame_start();
        video_vs_out = 1'b1;
        pix_q.delete();
        tick();
        video_vs_out = 1'b0;
        tick();
    endtask

    always @(negedge video_clk) begin
        logic [W-1:0] e;
        cyc++;
        if (fifo_enable) begin
            enable_count++;
            got_words.push_back(fifo_data_out);
            if (enable_count == lat_target) cross_cyc = cyc;
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            check("word", fifo_data_out, e);
        end
        if (AXI_FULL_BURST_VALID && !prev_valid) begin
            valid_rises++;
            if (lat_target != 0 && !lat_done && cross_cyc != 0) begin
                check("valid_latency", cyc - cross_cyc, 2);
                lat_done = 1'b1;
            end
        end
        if (AXI_FULL_BURST_VALID && AXI_FULL_BURST_READY) begin
            hs_count++;
            if (prev_hs) b2b_count++;
        end
        prev_hs    = AXI_FULL_BURST_VALID && AXI_FULL_BURST_READY;
        prev_valid = AXI_FULL_BURST_VALID;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_en, base_hs, base_rise;
        video_rst = 1'b1; video_vs_out = 1'b0; video_hs_out = 1'b0; video_de_out = 1'b0;
        video_data_out = '0; fifo_full = 1'b0; AXI_FULL_BURST_READY = 1'b0;
        tick(); tick(); tick();
        check("rst_enable", fifo_enable, 0);
        check("rst_data", fifo_data_out, 0);
        check("rst_valid", AXI_FULL_BURST_VALID, 0);
        check("rst_overflow", overflow, 0);
        check("rst_line_beats", line_beats, 0);
        video_rst = 1'b0;
        tick();
        frame_start();

        // 16-pixel line: four words, one burst request
        base_en = enable_count; base_rise = valid_rises;
        lat_target = enable_count + B;
        send_line(1, 16);
        tick();
        check("t1_words", enable_count - base_en, 4);
        check("t1_first_word", got_words[base_en], 128'hff000001ff000002ff000003ff000004);
        check("t1_valid", AXI_FULL_BURST_VALID, 1);
        check("t1_valid_rises", valid_rises - base_rise, 1);

        // 6-pixel line, then 2 more pixels on the next line
        frame_start();
        base_en = enable_count;
        send_line(1, 6);
`ifdef VIDEO_PACK_LINE_FLUSH_EN
        check("t2_words", enable_count - base_en, 2);
        check("t2_flush_word", got_words[got_words.size()-1], 128'hff000005ff000006ff000000ff000000);
`else
        check("t2_words", enable_count - base_en, 1);
`endif
        send_line(32'h11, 2);
`ifndef VIDEO_PACK_LINE_FLUSH_EN
        check("t2_carry_word", got_words[got_words.size()-1], 128'hff000005ff000006ff000011ff000012);
`endif

        // 12 words held with READY low, then three spaced handshakes
        frame_start();
        send_line(32'h20, 16);
        send_line(32'h40, 16);
        send_line(32'h60, 16);
        check("t3_valid_held", AXI_FULL_BURST_VALID, 1);
        check("t3_pend12", dut.pend_beats, 12);
        base_hs = hs_count;
        AXI_FULL_BURST_READY = 1'b1;
        for (int i = 0; i < 30 && (hs_count - base_hs) < 3; i++) tick();
        AXI_FULL_BURST_READY = 1'b0;
        tick(); tick(); tick();
        check("t3_handshakes", hs_count - base_hs, 3);
        check("t3_back_to_back", b2b_count, 0);
        check("t3_pend0", dut.pend_beats, 0);
        check("t3_valid_low", AXI_FULL_BURST_VALID, 0);

        // overflow is sticky until the next frame start
        frame_start();
        check("t4_ovf_clear", overflow, 0);
        fifo_full = 1'b1;
        send_line(32'h100, 4);
        fifo_full = 1'b0;
        check("t4_ovf_set", overflow, 1);
        send_line(32'h200, 4);
        check("t4_ovf_sticky", overflow, 1);
        video_vs_out = 1'b1;
        tick();
        check("t4_ovf_cleared", overflow, 0);
        video_vs_out = 1'b0;
        tick();

        // frame start coinciding with line end drops the partial word and the request
        frame_start();
        send_line(32'h300, 16);
        check("t5_valid_before", AXI_FULL_BURST_VALID, 1);
        video_de_out = 1'b1; video_data_out = 24'h400; tick();
        video_data_out = 24'h401; tick();
        video_de_out = 1'b0; video_vs_out = 1'b1;
        pix_q.delete();
        tick();
        check("t5_valid_dropped", AXI_FULL_BURST_VALID, 0);
        check("t5_slot_cnt", dut.slot_cnt, 0);
        video_vs_out = 1'b0;
        tick(); tick();
        send_line(32'h500, 4);

        // reset mid-line with a pending request
        frame_start();
        send_line(32'h600, 16);
        check("t6_valid_before", AXI_FULL_BURST_VALID, 1);
        video_de_out = 1'b1; video_data_out = 24'h700; tick();
        video_data_out = 24'h701; tick();
        video_data_out = 24'h702; video_rst = 1'b1;
        tick();
        pix_q.delete();
        check("t6_rst_enable", fifo_enable, 0);
        check("t6_rst_data", fifo_data_out, 0);
        check("t6_rst_valid", AXI_FULL_BURST_VALID, 0);
        check("t6_rst_line_beats", line_beats, 0);
        video_rst = 1'b0; video_de_out = 1'b0;
        tick();
        base_en = enable_count;
        send_line(32'h710, 4);
        check("t6_post_words", enable_count - base_en, 1);
        check("t6_post_word", got_words[got_words.size()-1], 128'hff000710ff000711ff000712ff000713);

        tick(); tick(); tick();
        check("drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
